// File: rtl/edc_corrector_if.sv
// Handshake bundle for the SEC-DED read-path corrector: read beat in, corrected beat out,
// error counters and the scrub write-back port.
interface edc_corrector_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              i_valid;
  logic              o_ready;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_data;
  logic [7:0]        i_syndrome;
  logic              o_valid;
  logic              i_ready;
  logic [31:0]       o_data;
  logic              o_ce;
  logic              o_ue;
  logic [CNT_W-1:0]  o_ce_count;
  logic [CNT_W-1:0]  o_ue_count;
  logic              i_clr_counts;
  logic              o_scrub_req;
  logic [ADDR_W-1:0] o_scrub_addr;
  logic [31:0]       o_scrub_data;
  logic              i_scrub_ack;
  logic              o_scrub_drop;

  // The corrector itself
  modport slave (
    input  i_valid, i_addr, i_data, i_syndrome, i_ready, i_clr_counts, i_scrub_ack,
    output o_ready, o_valid, o_data, o_ce, o_ue, o_ce_count, o_ue_count,
           o_scrub_req, o_scrub_addr, o_scrub_data, o_scrub_drop
  );

  // The surrounding read path / memory controller
  modport master (
    output i_valid, i_addr, i_data, i_syndrome, i_ready, i_clr_counts, i_scrub_ack,
    input  o_ready, o_valid, o_data, o_ce, o_ue, o_ce_count, o_ue_count,
           o_scrub_req, o_scrub_addr, o_scrub_data, o_scrub_drop
  );
endinterface

// File: rtl/edc_corrector.sv
// (40,32) Hsiao SEC-DED read-path corrector: flips a single bad data bit, flags CE/UE,
// keeps saturating error counters and holds a one-entry scrub write-back buffer.
module edc_corrector #(
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 16,
  parameter bit SCRUB_EN = 1'b1
) (
  input logic            i_clk,
  input logic            i_rst_n,
  edc_corrector_if.slave bus
);

  // Syndrome column of data bit k lives at H_COLS[8k +: 8]; d[31] is the leftmost entry.
  localparam logic [255:0] H_COLS = {
    8'h15, 8'h16, 8'h25, 8'h26, 8'h45, 8'h46, 8'h85, 8'h86,
    8'h19, 8'h1A, 8'h29, 8'h2A, 8'h49, 8'h4A, 8'h89, 8'h8A,
    8'h51, 8'h91, 8'h52, 8'h92, 8'h54, 8'h94, 8'h58, 8'h98,
    8'h61, 8'hA1, 8'h62, 8'hA2, 8'h64, 8'hA4, 8'h68, 8'hA8
  };

  typedef enum logic {S_IDLE, S_REQ} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              valid_q, ce_q, ue_q, drop_q;
  logic [31:0]       data_q, scrub_data_q;
  logic [ADDR_W-1:0] scrub_addr_q;
  logic [CNT_W-1:0]  ce_cnt_q, ce_cnt_d, ue_cnt_q, ue_cnt_d;
  state_t            state_q;

  logic [31:0] flip_mask, fix_data;
  logic        col_hit, ce_c, ue_c, accept, ce_acc;

  // Column match flips at most one bit; check-bit and double errors leave the mask empty.
  always_comb begin
    flip_mask = '0;
    col_hit   = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (bus.i_syndrome == H_COLS[k*8 +: 8]) begin
        flip_mask[k] = 1'b1;
        col_hit      = 1'b1;
      end
    end
    ce_c     = col_hit | $onehot(bus.i_syndrome);
    ue_c     = (bus.i_syndrome != 8'h00) & ~ce_c;
    fix_data = bus.i_data ^ flip_mask;
  end

  assign bus.o_ready = ~valid_q | bus.i_ready;
  assign accept      = bus.i_valid & bus.o_ready;
  assign ce_acc      = accept & ce_c & SCRUB_EN;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ce_q    <= 1'b0;
      ue_q    <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= fix_data;
      ce_q    <= ce_c;
      ue_q    <= ue_c;
    end else if (bus.i_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Clear has priority over a same-cycle increment.
  always_comb begin
    ce_cnt_d = ce_cnt_q;
    ue_cnt_d = ue_cnt_q;
    if (bus.i_clr_counts) begin
      ce_cnt_d = '0;
      ue_cnt_d = '0;
    end else if (accept) begin
      if (ce_c) ce_cnt_d = sat_inc(ce_cnt_q);
      if (ue_c) ue_cnt_d = sat_inc(ue_cnt_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ce_cnt_q <= '0;
      ue_cnt_q <= '0;
    end else begin
      ce_cnt_q <= ce_cnt_d;
      ue_cnt_q <= ue_cnt_d;
    end
  end

  // Scrub buffer: an ack frees the slot in the same cycle a new CE may refill it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      scrub_addr_q <= '0;
      scrub_data_q <= '0;
      drop_q       <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ce_acc) begin
            state_q      <= S_REQ;
            scrub_addr_q <= bus.i_addr;
            scrub_data_q <= fix_data;
          end
        end
        S_REQ: begin
          if (bus.i_scrub_ack) begin
            if (ce_acc) begin
              scrub_addr_q <= bus.i_addr;
              scrub_data_q <= fix_data;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (ce_acc) begin
            drop_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.o_valid      = valid_q;
  assign bus.o_data       = data_q;
  assign bus.o_ce         = ce_q;
  assign bus.o_ue         = ue_q;
  assign bus.o_ce_count   = ce_cnt_q;
  assign bus.o_ue_count   = ue_cnt_q;
  assign bus.o_scrub_req  = (state_q == S_REQ);
  assign bus.o_scrub_addr = scrub_addr_q;
  assign bus.o_scrub_data = scrub_data_q;
  assign bus.o_scrub_drop = drop_q;

endmodule

// File: tb/tb_edc_corrector.sv
// Scoreboard bench for edc_corrector: errors injected into random words, expected beats
// queued at acceptance and popped by an independent monitor on the falling edge.
module tb_edc_corrector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  edc_corrector_if #(.ADDR_W(32), .CNT_W(16)) bus ();
  edc_corrector_if #(.ADDR_W(32), .CNT_W(2))  bus2 ();

  edc_corrector #(.ADDR_W(32), .CNT_W(16), .SCRUB_EN(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  edc_corrector #(.ADDR_W(32), .CNT_W(2), .SCRUB_EN(1'b0)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus2));

  assign bus2.i_valid      = bus.i_valid;
  assign bus2.i_addr       = bus.i_addr;
  assign bus2.i_data       = bus.i_data;
  assign bus2.i_syndrome   = bus.i_syndrome;
  assign bus2.i_ready      = bus.i_ready;
  assign bus2.i_clr_counts = bus.i_clr_counts;
  assign bus2.i_scrub_ack  = bus.i_scrub_ack;

  // Hsiao data columns, index = data bit position
  localparam logic [7:0] COLS [0:31] = '{
    8'hA8, 8'h68, 8'hA4, 8'h64, 8'hA2, 8'h62, 8'hA1, 8'h61,
    8'h98, 8'h58, 8'h94, 8'h54, 8'h92, 8'h52, 8'h91, 8'h51,
    8'h8A, 8'h89, 8'h4A, 8'h49, 8'h2A, 8'h29, 8'h1A, 8'h19,
    8'h86, 8'h85, 8'h46, 8'h45, 8'h26, 8'h25, 8'h16, 8'h15
  };

  typedef struct {
    logic [31:0] d;
    bit          ce;
    bit          ue;
  } beat_t;

  beat_t q[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] exp_d;
  bit          exp_ce, exp_ue, rnd;
  int          m_ce16, m_ue16, m_ce2, m_ue2;
  bit          m_pend, m_drop;
  logic [31:0] m_saddr, m_sdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Reference model: what the stage should hold after each clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ce16 = 0; m_ue16 = 0; m_ce2 = 0; m_ue2 = 0;
      m_pend = 0; m_drop = 0; m_saddr = '0; m_sdata = '0;
    end else begin
      m_drop = 0;
      if (bus.i_valid && (!q.size() || bus.i_ready || !bus.o_valid) && bus.o_ready) begin
        q.push_back('{d: exp_d, ce: exp_ce, ue: exp_ue});
        if (bus.i_clr_counts) begin
          m_ce16 = 0; m_ue16 = 0; m_ce2 = 0; m_ue2 = 0;
        end else begin
          m_ce16 = sat(m_ce16 + int'(exp_ce), 65535);
          m_ue16 = sat(m_ue16 + int'(exp_ue), 65535);
          m_ce2  = sat(m_ce2 + int'(exp_ce), 3);
          m_ue2  = sat(m_ue2 + int'(exp_ue), 3);
        end
        if (exp_ce) begin
          if (!m_pend || bus.i_scrub_ack) begin
            m_pend = 1; m_saddr = bus.i_addr; m_sdata = exp_d;
          end else begin
            m_drop = 1;
          end
        end else if (m_pend && bus.i_scrub_ack) begin
          m_pend = 0;
        end
      end else begin
        if (bus.i_clr_counts) begin
          m_ce16 = 0; m_ue16 = 0; m_ce2 = 0; m_ue2 = 0;
        end
        if (m_pend && bus.i_scrub_ack) m_pend = 0;
      end
    end
  end

  bit          hold;
  logic [31:0] hold_d;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("o_ready", bus.o_ready, !bus.o_valid || bus.i_ready);
      if (hold) begin
        chk("hold_valid", bus.o_valid, 1);
        chk("hold_data", bus.o_data, hold_d);
      end
      chk("ce_ue_excl", bus.o_valid && bus.o_ce && bus.o_ue, 0);
      if (bus.o_valid && bus.i_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat actual=%0h required=none", bus.o_data);
        end else begin
          beat_t b;
          b = q.pop_front();
          chk("o_data", bus.o_data, b.d);
          chk("o_ce", bus.o_ce, b.ce);
          chk("o_ue", bus.o_ue, b.ue);
        end
      end
      chk("ce_count", bus.o_ce_count, m_ce16);
      chk("ue_count", bus.o_ue_count, m_ue16);
      chk("ce_count_w2", bus2.o_ce_count, m_ce2);
      chk("ue_count_w2", bus2.o_ue_count, m_ue2);
      chk("scrub_req", bus.o_scrub_req, m_pend);
      if (m_pend) begin
        chk("scrub_addr", bus.o_scrub_addr, m_saddr);
        chk("scrub_data", bus.o_scrub_data, m_sdata);
      end
      chk("scrub_drop", bus.o_scrub_drop, m_drop);
      chk("scrub_off_req", bus2.o_scrub_req | bus2.o_scrub_drop, 0);
      hold   = bus.o_valid && !bus.i_ready;
      hold_d = bus.o_data;
    end else begin
      hold = 0;
    end
  end

  task automatic randomize_ctl();
    if (rnd) begin
      bus.i_ready      = ($urandom_range(0, 3) != 0);
      bus.i_scrub_ack  = ($urandom_range(0, 3) == 0);
      bus.i_clr_counts = ($urandom_range(0, 31) == 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      randomize_ctl();
    end
  endtask

  task automatic send(input logic [31:0] raw, input logic [7:0] syn, input logic [31:0] addr,
                      input logic [31:0] ed, input bit ece, input bit eue);
    bit acc, done;
    bus.i_valid = 1'b1; bus.i_data = raw; bus.i_syndrome = syn; bus.i_addr = addr;
    exp_d = ed; exp_ce = ece; exp_ue = eue;
    done = 0;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      acc = bus.o_ready;
      @(posedge clk); #1;
      randomize_ctl();
      if (acc) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=stalled required=accepted");
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic gen(output logic [31:0] raw, output logic [7:0] syn, output logic [31:0] ed,
                     output bit ce, output bit ue);
    logic [31:0] d;
    int kind, k, a, b;
    d = $urandom; kind = $urandom_range(0, 4);
    raw = d; syn = 8'h00; ed = d; ce = 0; ue = 0;
    case (kind)
      1: begin
        k = $urandom_range(0, 31);
        raw = d ^ (32'h1 << k); syn = COLS[k]; ce = 1;
      end
      2: begin
        k = $urandom_range(0, 7);
        syn = 8'h01 << k; ce = 1;
      end
      3: begin
        a = $urandom_range(0, 39);
        b = (a + $urandom_range(1, 39)) % 40;
        foreach (COLS[p]) if (p == a || p == b) begin raw[p] = ~raw[p]; syn ^= COLS[p]; end
        if (a >= 32) syn ^= 8'h01 << (a - 32);
        if (b >= 32) syn ^= 8'h01 << (b - 32);
        ed = raw; ue = 1;
      end
      4: begin
        syn = 8'($urandom);
        if (syn != 8'h00) begin
          foreach (COLS[p]) if (COLS[p] == syn) begin ed = d ^ (32'h1 << p); ce = 1; end
          if (!ce && $countones(syn) == 1) ce = 1;
          if (!ce) ue = 1;
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    logic [31:0] r, e;
    logic [7:0]  s;
    bit          c, u;
    bus.i_valid = 0; bus.i_addr = '0; bus.i_data = '0; bus.i_syndrome = '0;
    bus.i_ready = 1; bus.i_clr_counts = 0; bus.i_scrub_ack = 0;
    exp_d = '0; exp_ce = 0; exp_ue = 0; rnd = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_ce_count", bus.o_ce_count, 0);
    chk("rst_scrub_req", bus.o_scrub_req, 0);
    chk("rst_scrub_addr", bus.o_scrub_addr, 0);
    chk("rst_scrub_drop", bus.o_scrub_drop, 0);
    rst_n = 1;
    idle(2);

    send(32'hDEADBEEF, 8'h00, 32'h0,   32'hDEADBEEF, 0, 0);
    send(32'hDEADBEEF, 8'h15, 32'h100, 32'h5EADBEEF, 1, 0);
    idle(3);
    bus.i_scrub_ack = 1; idle(1); bus.i_scrub_ack = 0;
    send(32'h12345678, 8'h01, 32'h104, 32'h12345678, 1, 0);
    send(32'h12345678, 8'h03, 32'h108, 32'h12345678, 0, 1);
    send(32'h12345678, 8'h07, 32'h10C, 32'h12345678, 0, 1);
    bus.i_scrub_ack = 1; idle(1); bus.i_scrub_ack = 0;

    // Back-to-back CEs with ack withheld, then ack coinciding with the third
    send(32'h0000_0001, 8'hA8, 32'h200, 32'h0000_0000, 1, 0);
    send(32'h8000_0000, 8'h15, 32'h204, 32'h0000_0000, 1, 0);
    bus.i_scrub_ack = 1;
    send(32'hFFFF_FFFF, 8'h61, 32'h208, 32'hFFFF_FF7F, 1, 0);
    bus.i_scrub_ack = 0;
    idle(2);
    bus.i_scrub_ack = 1; idle(1); bus.i_scrub_ack = 0;

    // Downstream stall for 5 cycles
    send(32'hCAFE_F00D, 8'h00, 32'h300, 32'hCAFE_F00D, 0, 0);
    bus.i_ready = 0;
    fork
      send(32'hA5A5_A5A5, 8'h98, 32'h304, 32'hA5A5_A4A5, 1, 0);
      begin idle(5); bus.i_ready = 1; end
    join
    idle(2);

    // Clear racing a CE increment
    bus.i_clr_counts = 1;
    send(32'h0F0F_0F0F, 8'h51, 32'h400, 32'h0F0F_8F0F, 1, 0);
    bus.i_clr_counts = 0;
    bus.i_scrub_ack = 1; idle(1); bus.i_scrub_ack = 0;

    // Asynchronous reset while a scrub is pending
    send(32'h1111_1111, 8'h02, 32'h500, 32'h1111_1111, 1, 0);
    idle(1);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("async_scrub_req", bus.o_scrub_req, 0);
    chk("async_valid", bus.o_valid, 0);
    chk("async_ce_count", bus.o_ce_count, 0);
    @(posedge clk); #1;
    rst_n = 1;
    idle(1);

    rnd = 1;
    for (int i = 0; i < 400; i++) begin
      gen(r, s, e, c, u);
      send(r, s, 32'($urandom), e, c, u);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    rnd = 0;
    bus.i_ready = 1; bus.i_scrub_ack = 1; bus.i_clr_counts = 0;
    idle(5);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
